// File: rtl/demux_pkg.sv
// +----------------------------------------------------------------------+
// | demux_pkg : shared widths and channel-select type for demux1a4_buf   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package demux_pkg;

  localparam int W_DEF  = 4;
  localparam int NUM_CH = 4;

  typedef logic [1:0] chsel_t;

endpackage

`default_nettype wire

// File: rtl/chan_buf.sv
// +----------------------------------------------------------------------+
// | chan_buf : one-entry channel buffer with load, drain and full flag   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module chan_buf #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a drain keeps the entry full with new data.
  always_comb begin
    full_d = full_q && !ready_i;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/demux1a4_buf.sv
// +----------------------------------------------------------------------+
// | demux1a4_buf : 1-to-4 demultiplexer with per-channel one-entry bufs  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module demux1a4_buf
  import demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] Din,
  input  logic [1:0]   Sel,
  input  logic         DinValid,
  output logic         DinReady,
  input  logic         AutoMode,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic [3:0]   YValid,
  input  logic [3:0]   YReady,
  output logic [1:0]   AutoPtr
);

  chsel_t              autoptr_q, autoptr_d;
  chsel_t              dest;
  logic                accept;
  logic [NUM_CH-1:0]   load;
  logic [W-1:0]        y_data [NUM_CH];

  assign dest = AutoMode ? autoptr_q : chsel_t'(Sel);

  // Ready passes through when the destination drains in the same cycle.
  assign DinReady = !YValid[dest] || YReady[dest];
  assign accept   = DinValid && DinReady;
  assign load     = accept ? (NUM_CH'(1) << dest) : '0;

  always_comb begin
    autoptr_d = autoptr_q;
    if (accept && AutoMode) begin
      autoptr_d = autoptr_q + 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      autoptr_q <= '0;
    end else begin
      autoptr_q <= autoptr_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      chan_buf #(.W(W)) u_chan (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .load_i  (load[i]),
        .din_i   (Din),
        .ready_i (YReady[i]),
        .valid_o (YValid[i]),
        .data_o  (y_data[i])
      );
    end
  endgenerate

  assign Y0      = y_data[0];
  assign Y1      = y_data[1];
  assign Y2      = y_data[2];
  assign Y3      = y_data[3];
  assign AutoPtr = autoptr_q;

endmodule

`default_nettype wire

// File: tb/tb_demux1a4_buf.sv
// +----------------------------------------------------------------------+
// | tb_demux1a4_buf : table-driven bench with expected-state scoreboard  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_demux1a4_buf;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] Din;
  logic [1:0] Sel;
  logic       DinValid;
  logic       DinReady;
  logic       AutoMode;
  logic [3:0] Y0, Y1, Y2, Y3;
  logic [3:0] YValid;
  logic [3:0] YReady;
  logic [1:0] AutoPtr;

  demux1a4_buf #(.W(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Din      (Din),
    .Sel      (Sel),
    .DinValid (DinValid),
    .DinReady (DinReady),
    .AutoMode (AutoMode),
    .Y0       (Y0),
    .Y1       (Y1),
    .Y2       (Y2),
    .Y3       (Y3),
    .YValid   (YValid),
    .YReady   (YReady),
    .AutoPtr  (AutoPtr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  din;
    logic [1:0]  sel;
    logic        vld;
    logic        am;
    logic [3:0]  yr;
    logic        chk_rdy;
    logic        rdy;
    logic [15:0] y;     // {Y3,Y2,Y1,Y0}
    logic [3:0]  yv;
    logic [1:0]  ptr;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  yv;
    logic [1:0]  ptr;
  } exp_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(logic rst, logic [3:0] din, logic [1:0] sel, logic vld,
                              logic am, logic [3:0] yr, logic chk_rdy, logic rdy,
                              logic [15:0] y, logic [3:0] yv, logic [1:0] ptr);
    vec_t v;
    v.rst = rst; v.din = din; v.sel = sel; v.vld = vld; v.am = am; v.yr = yr;
    v.chk_rdy = chk_rdy; v.rdy = rdy; v.y = y; v.yv = yv; v.ptr = ptr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
  endtask

  task automatic drive(input logic rst, input logic [3:0] din, input logic [1:0] sel,
                       input logic vld, input logic am, input logic [3:0] yr);
    Reset = rst; Din = din; Sel = sel; DinValid = vld; AutoMode = am; YReady = yr;
  endtask

  task automatic check_post(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty step %0d: got 0 entries want 1", idx);
    end else begin
      e = sb.pop_front();
      chk("Y3..Y0", idx, {Y3, Y2, Y1, Y0}, e.y);
      chk("YValid", idx, {12'd0, YValid}, {12'd0, e.yv});
      chk("AutoPtr", idx, {14'd0, AutoPtr}, {14'd0, e.ptr});
    end
  endtask

  initial begin
    exp_t        e;
    logic [15:0] ymodel;
    logic [1:0]  ch;

    //               rst din   sel  vld am  yr       chk rdy  y         yv       ptr
    vecs[0]  = mk(1, 4'h0, 2'd0, 0, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 2'd0);
    vecs[1]  = mk(0, 4'h0, 2'd0, 0, 0, 4'b0000, 1, 1, 16'h0000, 4'b0000, 2'd0);
    vecs[2]  = mk(0, 4'hA, 2'd2, 1, 0, 4'b0000, 1, 1, 16'h0A00, 4'b0100, 2'd0);
    vecs[3]  = mk(0, 4'h5, 2'd2, 1, 0, 4'b0000, 1, 0, 16'h0A00, 4'b0100, 2'd0);
    vecs[4]  = mk(0, 4'h5, 2'd2, 1, 0, 4'b0100, 1, 1, 16'h0500, 4'b0100, 2'd0);
    vecs[5]  = mk(0, 4'h0, 2'd2, 0, 0, 4'b0100, 1, 1, 16'h0500, 4'b0000, 2'd0);
    vecs[6]  = mk(0, 4'h0, 2'd2, 0, 0, 4'b1111, 1, 1, 16'h0500, 4'b0000, 2'd0);
    vecs[7]  = mk(0, 4'h1, 2'd3, 1, 1, 4'b1111, 1, 1, 16'h0501, 4'b0001, 2'd1);
    vecs[8]  = mk(0, 4'h2, 2'd3, 1, 1, 4'b1111, 1, 1, 16'h0521, 4'b0010, 2'd2);
    vecs[9]  = mk(0, 4'h3, 2'd3, 1, 1, 4'b1111, 1, 1, 16'h0321, 4'b0100, 2'd3);
    vecs[10] = mk(0, 4'h4, 2'd3, 1, 1, 4'b1111, 1, 1, 16'h4321, 4'b1000, 2'd0);
    vecs[11] = mk(0, 4'h5, 2'd3, 1, 1, 4'b1111, 1, 1, 16'h4325, 4'b0001, 2'd1);
    vecs[12] = mk(0, 4'h6, 2'd3, 1, 1, 4'b0000, 1, 1, 16'h4365, 4'b0011, 2'd2);
    vecs[13] = mk(0, 4'h8, 2'd0, 1, 0, 4'b0001, 1, 1, 16'h4368, 4'b0011, 2'd2);
    vecs[14] = mk(0, 4'h9, 2'd0, 1, 0, 4'b0001, 1, 1, 16'h4369, 4'b0011, 2'd2);
    vecs[15] = mk(0, 4'h7, 2'd0, 1, 1, 4'b0000, 1, 1, 16'h4769, 4'b0111, 2'd3);
    vecs[16] = mk(0, 4'hF, 2'd1, 1, 0, 4'b0000, 1, 0, 16'h4769, 4'b0111, 2'd3);
    vecs[17] = mk(0, 4'hB, 2'd3, 1, 0, 4'b0100, 1, 1, 16'hB769, 4'b1011, 2'd3);
    vecs[18] = mk(1, 4'hE, 2'd0, 1, 1, 4'b1000, 1, 1, 16'h0000, 4'b0000, 2'd0);
    vecs[19] = mk(0, 4'h0, 2'd0, 0, 0, 4'b0000, 1, 1, 16'h0000, 4'b0000, 2'd0);
    vecs[20] = mk(0, 4'h3, 2'd1, 1, 0, 4'b0000, 1, 1, 16'h0030, 4'b0010, 2'd0);
    vecs[21] = mk(0, 4'hC, 2'd1, 1, 0, 4'b0010, 1, 1, 16'h00C0, 4'b0010, 2'd0);
    vecs[22] = mk(0, 4'h0, 2'd1, 0, 0, 4'b0010, 1, 1, 16'h00C0, 4'b0000, 2'd0);

    drive(1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].din, vecs[i].sel, vecs[i].vld, vecs[i].am, vecs[i].yr);
      #1;
      if (vecs[i].chk_rdy) chk("DinReady", i, {15'd0, DinReady}, {15'd0, vecs[i].rdy});
      e.y = vecs[i].y; e.yv = vecs[i].yv; e.ptr = vecs[i].ptr;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      check_post(i);
      @(negedge Clk);
    end

    // Back-to-back auto beats across two pointer wraps with all consumers ready.
    ymodel = 16'h00C0;
    ch     = 2'd0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'(k + 1), 2'd3, 1'b1, 1'b1, 4'b1111);
      #1;
      chk("DinReady_auto", 100 + k, {15'd0, DinReady}, 16'd1);
      ymodel[4*ch +: 4] = 4'(k + 1);
      e.y = ymodel; e.yv = 4'(1 << ch); e.ptr = ch + 2'd1;
      sb.push_back(e);
      ch = ch + 2'd1;
      @(posedge Clk);
      #1;
      check_post(100 + k);
      @(negedge Clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
